multi_pulse_generator: RTL

Multi-channel programmable pulse-train generator, the parametrised successor to the single-channel fixed-period pulse generator. Each of CHANNELS independent channels produces a registered waveform with programmable period and high-width, in continuous, one-shot or burst mode. Channels are configured through one shared write port. It drives timing strobes, PWM outputs and LED/servo style loads in the system.

---
 rtl/multi_pulse_generator_pkg.sv | 26 ++
 rtl/multi_pulse_generator_channel.sv | 143 ++++++++++++++
 rtl/multi_pulse_generator.sv | 49 ++++
 3 files changed

// File: rtl/multi_pulse_generator_pkg.sv
// Shared types for the multi-channel pulse-train generator.
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    MODE_CONT    = 2'd0,
    MODE_ONESHOT = 2'd1,
    MODE_BURST   = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Default field width; channels build their own N-wide copy of this layout.
  localparam int PG_N = 8;

  typedef struct packed {
    logic [PG_N-1:0] period;
    logic [PG_N-1:0] width;
    mode_t           mode;
    logic [PG_N-1:0] bursts;
  } chan_cfg_t;

endpackage

// File: rtl/multi_pulse_generator_channel.sv
// One pulse channel: shadow/active config, IDLE/RUN FSM, period and burst
// counters, registered out/done.
module pulse_channel
  import pulse_gen_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena_i,
  input  logic         we_i,
  input  logic [N-1:0] period_i,
  input  logic [N-1:0] width_i,
  input  mode_t        mode_i,
  input  logic [N-1:0] bursts_i,
  input  logic         start_i,
  input  logic         stop_i,
  output logic         out_o,
  output logic         busy_o,
  output logic         done_o
);

  // Same layout as chan_cfg_t, sized by this instance's N.
  typedef struct packed {
    logic [N-1:0] period;
    logic [N-1:0] width;
    mode_t        mode;
    logic [N-1:0] bursts;
  } cfg_t;

  state_t       state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] k_q, k_d;
  logic         out_q, out_d;
  logic         done_q, done_d;
  logic         pend_q, pend_d;
  cfg_t         act_q, act_d;
  cfg_t         shad_q, shad_d;

  cfg_t         wr_cfg;
  cfg_t         nxt_cfg;
  logic [N-1:0] k_inc;
  logic [N-1:0] b_max;
  logic         wrap;
  logic         term;

  assign wr_cfg  = '{period: period_i, width: width_i, mode: mode_i, bursts: bursts_i};
  // Config that takes effect at the next load point: a same-cycle write wins,
  // then any pending shadow, otherwise the active config is kept.
  assign nxt_cfg = we_i ? wr_cfg : (pend_q ? shad_q : act_q);
  assign k_inc   = k_q + N'(1);
  assign b_max   = (act_q.bursts == '0) ? N'(1) : act_q.bursts;
  assign wrap    = (cnt_q == act_q.period - N'(1));
  assign term    = (act_q.mode == MODE_ONESHOT) ||
                   ((act_q.mode == MODE_BURST) && (k_inc == b_max));

  // Next-state: config staging, FSM transitions, counters and output level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    out_d   = out_q;
    done_d  = 1'b0;
    pend_d  = pend_q;
    act_d   = act_q;
    shad_d  = shad_q;

    if (we_i) begin
      shad_d = wr_cfg;
      pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        // Nothing is running, so staged config becomes active right away.
        act_d  = nxt_cfg;
        pend_d = 1'b0;
        out_d  = 1'b0;
        if (start_i && !stop_i && (nxt_cfg.period != '0)) begin
          state_d = S_RUN;
          cnt_d   = '0;
          k_d     = '0;
          out_d   = (nxt_cfg.width != '0);
        end
      end
      default: begin
        if (stop_i) begin
          state_d = S_IDLE;
          out_d   = 1'b0;
        end else if (start_i || (ena_i && wrap)) begin
          // Restart or period boundary: both are load points for new config.
          act_d  = nxt_cfg;
          pend_d = 1'b0;
          cnt_d  = '0;
          k_d    = start_i ? '0 : k_inc;
          out_d  = (nxt_cfg.width != '0);
          if (!start_i && term) begin
            state_d = S_IDLE;
            out_d   = 1'b0;
            done_d  = 1'b1;
          end else if (nxt_cfg.period == '0) begin
            // A zero period cannot run; drop out quietly.
            state_d = S_IDLE;
            out_d   = 1'b0;
          end
        end else if (!ena_i) begin
          out_d = 1'b0;
        end else begin
          cnt_d = cnt_q + N'(1);
          out_d = ((cnt_q + N'(1)) < act_q.width);
        end
      end
    endcase
  end

  // State registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      out_q   <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
      act_q   <= '0;
      shad_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      out_q   <= out_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      shad_q  <= shad_d;
    end
  end

  assign out_o  = out_q;
  assign busy_o = (state_q == S_RUN);
  assign done_o = done_q;

endmodule

// File: rtl/multi_pulse_generator.sv
// Multi-channel pulse-train generator: decodes the shared config port into
// per-channel write enables and instantiates one pulse_channel per channel.
module multi_pulse_generator
  import pulse_gen_pkg::*;
#(
  parameter  int N        = 8,
  parameter  int CHANNELS = 4,
  localparam int CW       = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                cfg_we,
  input  logic [CW-1:0]       cfg_ch,
  input  logic [N-1:0]        cfg_period,
  input  logic [N-1:0]        cfg_width,
  input  logic [1:0]          cfg_mode,
  input  logic [N-1:0]        cfg_bursts,
  input  logic [CHANNELS-1:0] start,
  input  logic [CHANNELS-1:0] stop,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] done
);

  logic [CHANNELS-1:0] ch_we;

  // A cfg_ch value with no matching channel simply enables nobody.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign ch_we[g] = cfg_we && (cfg_ch == CW'(g));

    pulse_channel #(.N(N)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .ena_i    (ena),
      .we_i     (ch_we[g]),
      .period_i (cfg_period),
      .width_i  (cfg_width),
      .mode_i   (mode_t'(cfg_mode)),
      .bursts_i (cfg_bursts),
      .start_i  (start[g]),
      .stop_i   (stop[g]),
      .out_o    (out[g]),
      .busy_o   (busy[g]),
      .done_o   (done[g])
    );
  end

endmodule
